g18_flash_ctrl: RTL
===================

Name: g18_flash_ctrl

Overview:
- Sequences the 16-bit BPI flash (g18) bus: converts 32-bit Wishbone classic accesses into timed half-word flash cycles.
- Shares the flash between two requesters: port 0 is the instruction bus (boot/diag ROM fetch), port 1 is the data bus (flash command writes and reads).
- Sits in orpsoc between the bus fabric and the g18 pads; replaces direct g18 address/data driving.

Parameters:
- RD_WAIT, 8, cycles address/OE-valid to data sample per half-word read (≥1)
- WE_SETUP, 2, cycles address/data valid before WE falls (≥1)
- WE_PULSE, 4, cycles WE held low (≥1)
- TURNAROUND, 2, cycles CE/OE high between flash accesses (≥1)

Ports:
- sys_clk_i  in  1  system clock
- sys_rst_ni  in  1  asynchronous active-low reset
- wb0_/wb1_cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe, write
- wb0_/wb1_adr_i  in  24  byte address; [23:2] word, [1] half select for writes
- wb0_/wb1_dat_i  in  32  write data
- wb0_/wb1_sel_i  in  4  byte selects
- wb0_/wb1_dat_o  out  32  read data
- wb0_/wb1_ack_o, err_o  out  1 each  termination
- g18_adr_o  out  23  half-word address
- g18_dat_o  out  16  write data
- g18_dat_i  in  16  read data
- g18_dat_oe_o  out  1  1 = controller drives the data pads
- g18_cen_o, g18_oen_o, g18_wen_o  out  1 each  active-low chip, output and write enables

Behaviour:
- Reset: cen/oen/wen = 1; dat_oe = 0; g18_adr_o = 0; g18_dat_o = 0; all ack/err = 0; dat_o = 0; FSM in IDLE; round-robin pointer set so port 0 wins the first tie.
- Arbitration happens only in IDLE on req = cyc & stb.
  - One port requesting: that port is granted.
  - Both requesting: the port not granted last wins. The pointer updates on every grant.
- Address, we, data and sel are latched at grant (cycle 0).
- Read (we = 0), sel ignored. States RD_HI then RD_LO, RD_WAIT cycles each.
  - RD_HI drives adr {a[23:2],0}; RD_LO drives adr {a[23:2],1}. cen = oen = 0 throughout both.
  - The half-word is sampled on the last cycle of each state.
  - Big-endian: dat_o = {hi, lo}.
  - ack_o is a single-cycle pulse at cycle 2*RD_WAIT+1, with dat_o valid that cycle.
  - Default latency: 17 cycles.
- Write (we = 1): sel must be 1100 (half at a[23:1] with a[1] = 0, data [31:16]) or 0011 (a[1] = 1, data [15:0]).
  - Any other sel: err_o pulses at cycle 1, with no flash activity.
  - Sequence: WR_SETUP (WE_SETUP cycles: cen = 0, dat_oe = 1, adr/dat valid), then WR_PULSE (WE_PULSE cycles: wen = 0), then WR_HOLD (1 cycle: wen = 1, dat_oe stays 1).
  - ack pulses at cycle WE_SETUP+WE_PULSE+2. Default: 8.
- ACK state (1 cycle) drives ack/err to the granted port only. Then TURN: TURNAROUND cycles with cen = oen = wen = 1 and dat_oe = 0. Then IDLE.
  - Next grant is no earlier than TURNAROUND+1 cycles after ack.
- dat_oe and oen are never both active. dat_oe falls no earlier than the cycle wen rises.
- Granted port drops cyc mid-access: the flash sequence completes unchanged (a WE pulse is never truncated). ack/err are suppressed; go to TURN.
- Non-granted requester is held, with no ack, until re-arbitrated.
- Reset mid-access: immediate return to reset values. An aborted WE pulse is acceptable only under reset.
- A single down-counter, sized for max(RD_WAIT, WE_SETUP, WE_PULSE, TURNAROUND), is loaded on every state entry.

Decomposition:
- Package g18_ctrl_pkg:
  - state enum {IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, ACK, TURN}
  - default timing constants
  - G18_AW = 23, G18_DW = 16
- Sub-module g18_rr_arb: 2-requester round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Output: one-hot grant[1:0], plus last-grant pointer.

Test Plan:
- Flash model mem[0] = 0x1234, mem[1] = 0x5678; port 0 reads adr 0x000000 → wb0_dat_o = 0x12345678, ack at cycle 17; oen low cycles 1–16; g18_adr_o = 0 then 1.
- Port 1 writes adr 0x000402, sel 0011, dat 0x0000_00FF → g18_adr_o = 0x000201, g18_dat_o = 0x00FF; wen low cycles 3–6, dat_oe 1–7; ack at cycle 8.
- Port 1 writes sel 1111 → err_o at cycle 1, no ack; cen stays 1 throughout.
- Both ports request from reset, continuously → grants alternate 0,1,0,1; each pair of consecutive acks is separated by ≥ TURNAROUND+1 cycles plus access time.
- Port 1 drops cyc during WR_PULSE → wen low for the full 4 cycles, no ack on either port, IDLE after TURN.
- sys_rst_ni asserted during RD_LO → outputs return to reset values asynchronously; after release, a fresh read returns correct data.

Source files
------------

// File: rtl/g18_ctrl_pkg.sv
// Shared types and constants for the g18 BPI flash controller.
package g18_ctrl_pkg;

    localparam int G18_AW = 23;
    localparam int G18_DW = 16;

    localparam int RD_WAIT_DEF    = 8;
    localparam int WE_SETUP_DEF   = 2;
    localparam int WE_PULSE_DEF   = 4;
    localparam int TURNAROUND_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK,
        TURN
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/g18_rr_arb.sv
// Two-requester round-robin arbiter; pointer remembers the last granted port.
module g18_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/g18_flash_ctrl.sv
// Wishbone-to-g18 BPI flash sequencer: two requesters, half-word timed flash cycles.
module g18_flash_ctrl
    import g18_ctrl_pkg::*;
#(
    parameter int RD_WAIT    = RD_WAIT_DEF,
    parameter int WE_SETUP   = WE_SETUP_DEF,
    parameter int WE_PULSE   = WE_PULSE_DEF,
    parameter int TURNAROUND = TURNAROUND_DEF
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_ni,
    input  logic              wb0_cyc_i,
    input  logic              wb0_stb_i,
    input  logic              wb0_we_i,
    input  logic [23:0]       wb0_adr_i,
    input  logic [31:0]       wb0_dat_i,
    input  logic [3:0]        wb0_sel_i,
    output logic [31:0]       wb0_dat_o,
    output logic              wb0_ack_o,
    output logic              wb0_err_o,
    input  logic              wb1_cyc_i,
    input  logic              wb1_stb_i,
    input  logic              wb1_we_i,
    input  logic [23:0]       wb1_adr_i,
    input  logic [31:0]       wb1_dat_i,
    input  logic [3:0]        wb1_sel_i,
    output logic [31:0]       wb1_dat_o,
    output logic              wb1_ack_o,
    output logic              wb1_err_o,
    output logic [G18_AW-1:0] g18_adr_o,
    output logic [G18_DW-1:0] g18_dat_o,
    input  logic [G18_DW-1:0] g18_dat_i,
    output logic              g18_dat_oe_o,
    output logic              g18_cen_o,
    output logic              g18_oen_o,
    output logic              g18_wen_o
);

    localparam int MAXT = max4(RD_WAIT, WE_SETUP, WE_PULSE, TURNAROUND);
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              aborted;
    logic [G18_DW-1:0] hi_q;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        port;
    logic        advance;
    logic        busy;
    logic        cyc_g;
    logic        ok;
    logic        m_we;
    logic [23:0] m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;

    assign req     = {wb1_cyc_i & wb1_stb_i, wb0_cyc_i & wb0_stb_i};
    assign advance = (state == IDLE) && (req != 2'b00);

    // The arbiter pointer doubles as the index of the port owning the current access.
    g18_rr_arb u_arb (
        .clk     (sys_clk_i),
        .rst_n   (sys_rst_ni),
        .req     (req),
        .advance (advance),
        .grant   (grant),
        .last    (port)
    );

    always_comb begin
        m_we  = grant[1] ? wb1_we_i  : wb0_we_i;
        m_adr = grant[1] ? wb1_adr_i : wb0_adr_i;
        m_dat = grant[1] ? wb1_dat_i : wb0_dat_i;
        m_sel = grant[1] ? wb1_sel_i : wb0_sel_i;
        cyc_g = port ? wb1_cyc_i : wb0_cyc_i;
        busy  = (state == RD_HI) || (state == RD_LO) || (state == WR_SETUP) ||
                (state == WR_PULSE) || (state == WR_HOLD);
        ok    = !aborted && cyc_g;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            aborted      <= 1'b0;
            hi_q         <= '0;
            g18_adr_o    <= '0;
            g18_dat_o    <= '0;
            g18_dat_oe_o <= 1'b0;
            g18_cen_o    <= 1'b1;
            g18_oen_o    <= 1'b1;
            g18_wen_o    <= 1'b1;
            wb0_ack_o    <= 1'b0;
            wb0_err_o    <= 1'b0;
            wb0_dat_o    <= '0;
            wb1_ack_o    <= 1'b0;
            wb1_err_o    <= 1'b0;
            wb1_dat_o    <= '0;
        end else begin
            wb0_ack_o <= 1'b0;
            wb0_err_o <= 1'b0;
            wb1_ack_o <= 1'b0;
            wb1_err_o <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
            // A dropped cycle only suppresses termination; the flash sequence runs to completion.
            if (busy && !cyc_g) aborted <= 1'b1;

            case (state)
                IDLE: begin
                    if (advance) begin
                        aborted <= 1'b0;
                        if (!m_we) begin
                            state     <= RD_HI;
                            cnt       <= CW'(RD_WAIT - 1);
                            g18_adr_o <= {m_adr[23:2], 1'b0};
                            g18_cen_o <= 1'b0;
                            g18_oen_o <= 1'b0;
                        end else if (m_sel == 4'b1100 || m_sel == 4'b0011) begin
                            state        <= WR_SETUP;
                            cnt          <= CW'(WE_SETUP - 1);
                            g18_adr_o    <= m_adr[23:1];
                            g18_dat_o    <= (m_sel == 4'b1100) ? m_dat[31:16] : m_dat[15:0];
                            g18_cen_o    <= 1'b0;
                            g18_dat_oe_o <= 1'b1;
                        end else begin
                            state <= ACK;
                            cnt   <= '0;
                            if (grant[1]) wb1_err_o <= 1'b1;
                            else          wb0_err_o <= 1'b1;
                        end
                    end
                end
                RD_HI: begin
                    if (cnt == '0) begin
                        hi_q         <= g18_dat_i;
                        g18_adr_o[0] <= 1'b1;
                        cnt          <= CW'(RD_WAIT - 1);
                        state        <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (cnt == '0) begin
                        g18_cen_o <= 1'b1;
                        g18_oen_o <= 1'b1;
                        if (ok) begin
                            state <= ACK;
                            cnt   <= '0;
                            if (port) begin
                                wb1_ack_o <= 1'b1;
                                wb1_dat_o <= {hi_q, g18_dat_i};
                            end else begin
                                wb0_ack_o <= 1'b1;
                                wb0_dat_o <= {hi_q, g18_dat_i};
                            end
                        end else begin
                            state <= TURN;
                            cnt   <= CW'(TURNAROUND - 1);
                        end
                    end
                end
                WR_SETUP: begin
                    if (cnt == '0) begin
                        g18_wen_o <= 1'b0;
                        cnt       <= CW'(WE_PULSE - 1);
                        state     <= WR_PULSE;
                    end
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        g18_wen_o <= 1'b1;
                        cnt       <= '0;
                        state     <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    g18_cen_o    <= 1'b1;
                    g18_dat_oe_o <= 1'b0;
                    if (ok) begin
                        state <= ACK;
                        cnt   <= '0;
                        if (port) wb1_ack_o <= 1'b1;
                        else      wb0_ack_o <= 1'b1;
                    end else begin
                        state <= TURN;
                        cnt   <= CW'(TURNAROUND - 1);
                    end
                end
                ACK: begin
                    state <= TURN;
                    cnt   <= CW'(TURNAROUND - 1);
                end
                TURN: begin
                    if (cnt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
